// File: rtl/cosine_controller.sv
// Control FSM for the cosine/distance datapath: sequences the datapath states,
// serves the per-term Taylor coefficient and converts done/timeout into pulses.
module cosine_controller #(
    parameter int unsigned NTERMS       = 4,
    parameter int unsigned DONE_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        asyncclear,
    input  logic        sensor,
    input  logic        go,
    input  logic        done,
    output logic [2:0]  state,
    output logic [15:0] coefficient,
    output logic [2:0]  term_index,
    output logic        alarm,
    output logic        result_valid,
    output logic        error
);

    localparam int unsigned StateW = 3;
    localparam int unsigned CoefW  = 16;
    localparam int unsigned KW     = 3;
    localparam int unsigned CntW   = 8;

    localparam logic [KW-1:0]   LastK   = KW'(NTERMS - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DONE_TIMEOUT - 1);

    typedef enum logic [StateW-1:0] {
        StandBy           = 3'd0,
        Alert             = 3'd1,
        StartCalculation  = 3'd2,
        AccumulateTerms   = 3'd3,
        CalculateDistance = 3'd4
    } stateE;

    // Plain vector so that the unused codes 5..7 remain representable and recoverable
    logic [StateW-1:0] stateQ, stateD;
    logic [KW-1:0]     kQ, kD;
    logic [CntW-1:0]   cntQ, cntD;
    logic              resultValidQ, resultValidD;
    logic              errorQ, errorD;

    always_ff @(posedge clk or posedge asyncclear) begin
        if (asyncclear) begin
            stateQ       <= StandBy;
            kQ           <= '0;
            cntQ         <= '0;
            resultValidQ <= 1'b0;
            errorQ       <= 1'b0;
        end else begin
            stateQ       <= stateD;
            kQ           <= kD;
            cntQ         <= cntD;
            resultValidQ <= resultValidD;
            errorQ       <= errorD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        kD           = kQ;
        cntD         = cntQ;
        resultValidD = 1'b0;
        errorD       = 1'b0;
        case (stateQ)
            StandBy: begin
                if (sensor) stateD = Alert;
            end
            Alert: begin
                if (!sensor)  stateD = StandBy;
                else if (go)  stateD = StartCalculation;
            end
            StartCalculation: begin
                kD     = '0;
                stateD = AccumulateTerms;
            end
            AccumulateTerms: begin
                if (kQ == LastK) begin
                    cntD   = '0;
                    stateD = CalculateDistance;
                end else begin
                    kD = kQ + KW'(1);
                end
            end
            CalculateDistance: begin
                // done takes priority over an expiring timeout in the same cycle
                if (done) begin
                    resultValidD = 1'b1;
                    stateD       = StandBy;
                end else if (cntQ == LastCnt) begin
                    errorD = 1'b1;
                    stateD = StandBy;
                end else begin
                    cntD = cntQ + CntW'(1);
                end
            end
            default: stateD = StandBy;
        endcase
    end

    // -1/((2k+1)(2k+2)) in Q5.11, decoded from registered state only
    always_comb begin
        coefficient = '0;
        term_index  = '0;
        if (stateQ == AccumulateTerms) begin
            term_index = kQ;
            case (kQ)
                3'd0:    coefficient = CoefW'(16'hFC00);
                3'd1:    coefficient = CoefW'(16'hFF55);
                3'd2:    coefficient = CoefW'(16'hFFBC);
                3'd3:    coefficient = CoefW'(16'hFFDB);
                3'd4:    coefficient = CoefW'(16'hFFE9);
                default: coefficient = '0;
            endcase
        end
    end

    assign state        = stateQ;
    assign alarm        = (stateQ == Alert);
    assign result_valid = resultValidQ;
    assign error        = errorQ;

endmodule

// File: tb/tb_cosine_controller.sv
// Scoreboard bench for cosine_controller: three instances (NTERMS 4/1/5), directed
// flows push expected completions, a negedge monitor pops them on each pulse.
module tb_cosine_controller;

    localparam int unsigned NDut = 3;

    logic clk = 1'b0;
    logic asyncclear = 1'b0;
    logic sensor [NDut];
    logic go [NDut];
    logic done [NDut] = '{1'b0, 1'b0, 1'b0};
    logic [2:0]  state [NDut];
    logic [15:0] coefficient [NDut];
    logic [2:0]  termIndex [NDut];
    logic alarm [NDut];
    logic resultValid [NDut];
    logic error [NDut];

    bit doneEn [NDut];
    int calcAge [NDut] = '{0, 0, 0};

    int passCnt = 0;
    int totalCnt = 0;

    typedef struct {
        int          dutIdx;
        bit          isErr;
        int          nAcc;
        int          nCalc;
        logic [79:0] coefLog;
        logic [14:0] idxLog;
    } expT;

    expT expQ [$];

    int          accN [NDut] = '{0, 0, 0};
    int          calcN [NDut] = '{0, 0, 0};
    logic [79:0] coefLog [NDut] = '{80'h0, 80'h0, 80'h0};
    logic [14:0] idxLog [NDut] = '{15'h0, 15'h0, 15'h0};

    localparam logic [2:0]  NomSt   [8] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};
    localparam logic [15:0] NomCoef [8] = '{16'h0000, 16'hFC00, 16'hFF55, 16'hFFBC,
                                            16'hFFDB, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [2:0]  NomIdx  [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0};

    for (genvar g = 0; g < NDut; g++) begin : gDut
        cosine_controller #(
            .NTERMS       ((g == 0) ? 4 : ((g == 1) ? 1 : 5)),
            .DONE_TIMEOUT (8)
        ) dut (
            .clk          (clk),
            .asyncclear   (asyncclear),
            .sensor       (sensor[g]),
            .go           (go[g]),
            .done         (done[g]),
            .state        (state[g]),
            .coefficient  (coefficient[g]),
            .term_index   (termIndex[g]),
            .alarm        (alarm[g]),
            .result_valid (resultValid[g]),
            .error        (error[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chkWide(input string name, input logic [79:0] act, input logic [79:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Datapath model: done low on first CalculateDistance cycle, high from the second
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < NDut; g++) begin
            if (state[g] == 3'd4) calcAge[g] = calcAge[g] + 1;
            else                  calcAge[g] = 0;
            done[g] = doneEn[g] && (calcAge[g] >= 2);
        end
    end

    // Monitor: pops one expectation per result_valid/error pulse and traces each run
    always @(negedge clk) begin
        for (int g = 0; g < NDut; g++) begin
            if (resultValid[g] || error[g]) begin
                if (expQ.size() == 0) begin
                    chk("sb_unexpected_pulse", g * 16 + int'({resultValid[g], error[g]}), -1);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    chk("sb_dut", g, e.dutIdx);
                    chk("sb_kind", int'({resultValid[g], error[g]}), e.isErr ? 1 : 2);
                    chk("sb_state", int'(state[g]), 0);
                    chk("sb_acc_cycles", accN[g], e.nAcc);
                    chk("sb_calc_cycles", calcN[g], e.nCalc);
                    chkWide("sb_coef_log", coefLog[g], e.coefLog);
                    chkWide("sb_idx_log", 80'(idxLog[g]), 80'(e.idxLog));
                end
            end
            if (state[g] == 3'd2) begin
                accN[g] = 0; calcN[g] = 0; coefLog[g] = '0; idxLog[g] = '0;
            end else if (state[g] == 3'd3) begin
                accN[g]++;
                coefLog[g] = {coefLog[g][63:0], coefficient[g]};
                idxLog[g]  = {idxLog[g][11:0], termIndex[g]};
            end else if (state[g] == 3'd4) begin
                calcN[g]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int g = 0; g < NDut; g++) begin
            sensor[g] = 1'b0; go[g] = 1'b0; doneEn[g] = 1'b1;
        end

        // Reset state
        #1 asyncclear = 1'b1;
        #11;
        for (int g = 0; g < NDut; g++)
            chk("reset_outputs", int'({state[g], coefficient[g], termIndex[g], alarm[g],
                                       resultValid[g], error[g]}), 0);
        #10 asyncclear = 1'b0;
        tick();

        // Nominal flow, NTERMS=4
        sensor[0] = 1'b1;
        tick();
        chk("alert_state", int'(state[0]), 1);
        chk("alert_alarm", int'(alarm[0]), 1);
        go[0] = 1'b1;
        expQ.push_back('{0, 1'b0, 4, 2, 80'h0000_FC00_FF55_FFBC_FFDB, 15'o0123});
        for (int i = 0; i < 8; i++) begin
            tick();
            go[0] = 1'b0;
            chk("nom_state", int'(state[0]), int'(NomSt[i]));
            chk("nom_coef", int'(coefficient[0]), int'(NomCoef[i]));
            chk("nom_term_index", int'(termIndex[0]), int'(NomIdx[i]));
            chk("nom_result_valid", int'(resultValid[0]), (i == 7) ? 1 : 0);
        end
        tick();
        chk("b2b_realert", int'(state[0]), 1);
        chk("b2b_pulse_low", int'(resultValid[0]), 0);
        tick(2);
        chk("b2b_no_restart", int'(state[0]), 1);

        // Abort priority and ignored go
        sensor[0] = 1'b0; go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        chk("abort_priority", int'(state[0]), 0);
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        chk("go_in_standby", int'(state[0]), 0);

        // Timeout: done never rises
        doneEn[0] = 1'b0;
        sensor[0] = 1'b1;
        tick();
        go[0] = 1'b1;
        expQ.push_back('{0, 1'b1, 4, 8, 80'h0000_FC00_FF55_FFBC_FFDB, 15'o0123});
        tick();
        go[0] = 1'b0; sensor[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && state[0] != 3'd0; i++) begin
            if (state[0] == 3'd4) n++;
            tick();
        end
        chk("timeout_return", int'(state[0]), 0);
        chk("timeout_calc_cycles", n, 8);
        chk("timeout_error_pulse", int'({error[0], resultValid[0]}), 2);
        tick();
        chk("timeout_error_single", int'(error[0]), 0);
        doneEn[0] = 1'b1;

        // Boundary NTERMS=1
        sensor[1] = 1'b1;
        tick();
        go[1] = 1'b1;
        expQ.push_back('{1, 1'b0, 1, 2, 80'h0000_0000_0000_0000_FC00, 15'o0});
        tick();
        go[1] = 1'b0; sensor[1] = 1'b0;
        chk("n1_start", int'(state[1]), 2);
        tick();
        chk("n1_acc", int'({state[1], coefficient[1], termIndex[1]}), int'({3'd3, 16'hFC00, 3'd0}));
        tick();
        chk("n1_calc_after_one", int'(state[1]), 4);
        tick(2);
        chk("n1_done", int'({state[1], resultValid[1]}), 1);

        // Boundary NTERMS=5
        sensor[2] = 1'b1;
        tick();
        go[2] = 1'b1;
        expQ.push_back('{2, 1'b0, 5, 2, 80'hFC00_FF55_FFBC_FFDB_FFE9, 15'o01234});
        tick();
        go[2] = 1'b0; sensor[2] = 1'b0;
        tick(5);
        chk("n5_last_term", int'({state[2], coefficient[2], termIndex[2]}), int'({3'd3, 16'hFFE9, 3'd4}));
        tick();
        chk("n5_calc", int'(state[2]), 4);
        tick(2);
        chk("n5_done", int'({state[2], resultValid[2]}), 1);

        // Asynchronous reset mid-AccumulateTerms at k=2
        sensor[0] = 1'b1;
        tick();
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        tick(3);
        chk("pre_reset_k", int'({state[0], termIndex[0]}), int'({3'd3, 3'd2}));
        #3 asyncclear = 1'b1;
        #1;
        chk("async_reset_now", int'({state[0], coefficient[0], termIndex[0]}), 0);
        #2 asyncclear = 1'b0;
        sensor[0] = 1'b0;
        tick(12);
        chk("post_reset_idle", int'(state[0]), 0);

        // Illegal state code recovers to StandBy
        force gDut[0].dut.stateQ = 3'd6;
        #1;
        chk("forced_illegal", int'(state[0]), 6);
        release gDut[0].dut.stateQ;
        tick();
        chk("illegal_recover", int'({state[0], alarm[0], resultValid[0], error[0]}), 0);

        tick(3);
        chk("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/cosine_controller.md
Name: cosine_controller

Overview:
- Control unit driving the cosine/distance datapath. Sequences the five datapath states, supplies the per-iteration Taylor coefficient, and consumes the datapath `done` flag.
- Converts sensor/request handshakes into a single `result_valid` pulse, or an `error` pulse on timeout.
- Sits between the system-level request logic and the datapath. Its `state` output connects 1:1 to the datapath state input.

Parameters:
- NTERMS, 4, number of AccumulateTerms iterations; legal range 1..5.
- DONE_TIMEOUT, 8, cycles allowed in CalculateDistance for `done` to rise before flagging an error; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- asyncclear  in  1  asynchronous active-high reset.
- sensor  in  1  level; object-detected indication.
- go  in  1  single-cycle pulse; request a calculation while in Alert.
- done  in  1  datapath done flag.
- state  out  3  encoded datapath state.
- coefficient  out  16  signed Q5.11 series factor for the current term.
- term_index  out  3  current iteration k.
- alarm  out  1  high while in Alert.
- result_valid  out  1  one-cycle pulse; distance register holds a valid result.
- error  out  1  one-cycle pulse; done timeout.

Behaviour:
- Reset: asyncclear high forces immediately, regardless of clk:
  - state=0 (StandBy), k=0, timeout counter=0.
  - alarm=0, result_valid=0, error=0, coefficient=0x0000, term_index=0.
  - Reset mid-operation abandons the calculation with no result_valid/error pulse.
- State encoding:
  - StandBy=0, Alert=1, StartCalculation=2, AccumulateTerms=3, CalculateDistance=4.
  - Codes 5..7 are illegal and go to StandBy on the next edge.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- StandBy: sensor=1 → Alert next edge; otherwise stay.
- Alert: alarm=1.
  - sensor=0 → StandBy (abort). sensor=0 has priority over go in the same cycle.
  - sensor=1 and go=1 → StartCalculation.
  - Otherwise stay.
- StartCalculation: exactly one cycle. Clear k=0 → AccumulateTerms.
- AccumulateTerms: occupies exactly NTERMS consecutive cycles.
  - Each cycle: term_index=k; coefficient = ROM[k] = −1/((2k+1)(2k+2)) in Q5.11, rounded to nearest.
  - ROM values: k0 0xFC00, k1 0xFF55, k2 0xFFBC, k3 0xFFDB, k4 0xFFE9.
  - If k==NTERMS−1 → CalculateDistance with k unchanged, else k←k+1.
- Outside AccumulateTerms: coefficient=0x0000, term_index=0.
- CalculateDistance:
  - On entry the timeout counter is cleared; it increments each cycle spent here.
  - If done=1 is sampled, then next edge: result_valid=1 for one cycle → StandBy.
  - If the counter reaches DONE_TIMEOUT without done, then next edge: error=1 for one cycle → StandBy.
  - done and timeout in the same cycle: done wins (result_valid, no error).
- Expected datapath timing: done is sampled low on the first CalculateDistance cycle and high on the second. A nominal calculation therefore lasts 1 (Start) + NTERMS + 2 cycles, with result_valid in the cycle after the last CalculateDistance cycle.
- Ignored inputs:
  - go outside Alert is ignored.
  - sensor is ignored outside StandBy and Alert; a calculation in progress always completes or times out.
  - done outside CalculateDistance is ignored.
- Back-to-back: after result_valid, StandBy samples sensor again. A still-high sensor re-enters Alert on the following edge; no automatic restart without a new go.

Test Plan:
- Reset: assert asyncclear mid-AccumulateTerms (k=2) between clock edges → state=0, coefficient=0x0000, term_index=0 immediately; no result_valid after release.
- Nominal flow, NTERMS=4: sensor=1, go pulse in Alert, datapath model raises done one cycle after CalculateDistance entry.
  - state sequence 0,1,2,3,3,3,3,4,4 then 0.
  - coefficient 0xFC00,0xFF55,0xFFBC,0xFFDB on the four AccumulateTerms cycles.
  - result_valid single pulse coincident with the return to StandBy.
- Abort/priority: in Alert drive sensor=0 and go=1 in the same cycle → StandBy, no StartCalculation. A go pulse in StandBy is ignored.
- Timeout, DONE_TIMEOUT=8: hold done=0 → exactly 8 CalculateDistance cycles, error pulse once, result_valid never.
- Boundary NTERMS=1 and NTERMS=5: exactly 1 / 5 AccumulateTerms cycles. For NTERMS=5 the last coefficient is 0xFFE9 with term_index=4.
- Illegal state: force the state register to 6 → StandBy on the next edge with all pulses low.
